// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the inst (m0) and data (m1) masters.
// Define MEM_ARB_PERF_CNT_EN to add per-master transfer and conflict counters.
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      MEM_W_BYTE = 2'd0,
      MEM_W_HALF = 2'd1,
      MEM_W_WORD = 2'd2
   } mem_w_size_e;
endpackage

// state     | meaning
// S_IDLE    | no grant locked; arbitrate among valid masters each cycle
// S_LOCK_M0 | m0 was granted but slave stalled; m0 held until its transfer
// S_LOCK_M1 | m1 was granted but slave stalled; m1 held until its transfer
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter bit DATA_PRIORITY = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_m0_valid,
   input  logic                  i_m0_w_en,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [DATA_WIDTH-1:0] i_m0_w_data,
   input  mem_w_size_e           i_m0_w_size,
   output logic                  o_m0_ready,
   output logic [DATA_WIDTH-1:0] o_m0_r_data,
   input  logic                  i_m1_valid,
   input  logic                  i_m1_w_en,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [DATA_WIDTH-1:0] i_m1_w_data,
   input  mem_w_size_e           i_m1_w_size,
   output logic                  o_m1_ready,
   output logic [DATA_WIDTH-1:0] o_m1_r_data,
   output logic                  o_s_valid,
   output logic                  o_s_w_en,
   output logic [ADDR_WIDTH-1:0] o_s_addr,
   output logic [DATA_WIDTH-1:0] o_s_w_data,
   output mem_w_size_e           o_s_w_size,
   input  logic                  i_s_ready,
   input  logic [DATA_WIDTH-1:0] i_s_r_data
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]           o_m0_xfer_cnt,
   output logic [31:0]           o_m1_xfer_cnt,
   output logic [31:0]           o_conflict_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_LOCK_M0, S_LOCK_M1} state_e;
   typedef enum logic [1:0] {LAST_NONE, LAST_M0, LAST_M1} last_e;

   state_e r_state;
   state_e w_next_state;
   last_e  r_last;
   logic   r_rsp_owner;
   logic   w_gnt_vld;
   logic   w_gnt;
   logic   w_xfer;

   always_comb begin
      w_next_state = r_state;
      w_gnt_vld    = 1'b0;
      w_gnt        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_m0_valid && i_m1_valid) begin
               w_gnt_vld = 1'b1;
               case (r_last)
                  LAST_M0: w_gnt = 1'b1;
                  LAST_M1: w_gnt = 1'b0;
                  default: w_gnt = DATA_PRIORITY;
               endcase
            end else if (i_m0_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt     = 1'b0;
            end else if (i_m1_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt     = 1'b1;
            end
            if (w_gnt_vld && !i_s_ready)
               w_next_state = w_gnt ? S_LOCK_M1 : S_LOCK_M0;
         end
         S_LOCK_M0: begin
            w_gnt     = 1'b0;
            w_gnt_vld = i_m0_valid;
            if (!i_m0_valid || i_s_ready)
               w_next_state = S_IDLE;
         end
         S_LOCK_M1: begin
            w_gnt     = 1'b1;
            w_gnt_vld = i_m1_valid;
            if (!i_m1_valid || i_s_ready)
               w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
      // Outputs go quiet the moment reset asserts, even with masters still requesting.
      w_gnt_vld = w_gnt_vld & i_rst_n;
   end

   assign w_xfer = w_gnt_vld & i_s_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_last      <= LAST_NONE;
         r_rsp_owner <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_xfer) begin
            r_last      <= w_gnt ? LAST_M1 : LAST_M0;
            r_rsp_owner <= w_gnt;
         end
      end
   end

   assign o_s_valid   = w_gnt_vld;
   assign o_s_w_en    = w_gnt_vld & (w_gnt ? i_m1_w_en : i_m0_w_en);
   assign o_s_addr    = w_gnt_vld ? (w_gnt ? i_m1_addr : i_m0_addr) : '0;
   assign o_s_w_data  = w_gnt_vld ? (w_gnt ? i_m1_w_data : i_m0_w_data) : '0;
   assign o_s_w_size  = w_gnt_vld ? (w_gnt ? i_m1_w_size : i_m0_w_size) : MEM_W_BYTE;
   assign o_m0_ready  = w_gnt_vld & ~w_gnt & i_s_ready;
   assign o_m1_ready  = w_gnt_vld &  w_gnt & i_s_ready;
   assign o_m0_r_data = (i_rst_n && !r_rsp_owner) ? i_s_r_data : '0;
   assign o_m1_r_data = (i_rst_n &&  r_rsp_owner) ? i_s_r_data : '0;

`ifdef MEM_ARB_PERF_CNT_EN
   logic        w_conflict;
   logic [31:0] r_m0_xfer_cnt;
   logic [31:0] r_m1_xfer_cnt;
   logic [31:0] r_conflict_cnt;

   always_comb begin
      w_conflict = 1'b0;
      case (r_state)
         S_LOCK_M0: w_conflict = i_m1_valid;
         S_LOCK_M1: w_conflict = i_m0_valid;
         default:   w_conflict = i_m0_valid & i_m1_valid;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_m0_xfer_cnt  <= '0;
         r_m1_xfer_cnt  <= '0;
         r_conflict_cnt <= '0;
      end else begin
         if (w_xfer && !w_gnt) r_m0_xfer_cnt <= r_m0_xfer_cnt + 32'd1;
         if (w_xfer &&  w_gnt) r_m1_xfer_cnt <= r_m1_xfer_cnt + 32'd1;
         if (w_conflict)       r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end

   assign o_m0_xfer_cnt  = r_m0_xfer_cnt;
   assign o_m1_xfer_cnt  = r_m1_xfer_cnt;
   assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-master, one-slave arbiter on the core memory bus.
- Shares a single unified memory port between the Cpu instruction fetch port (master 0) and data port (master 1).
- Uses the existing valid/ready bus protocol, where read data returns one cycle after the handshake.
- Sits between Cpu and the memory-map decode, replacing the dedicated instruction memory path.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- DATA_PRIORITY, 1, on a fresh conflict with no prior grant history (first conflict after reset): 1 = grant data first, 0 = grant inst first.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_m0_valid, i_m0_w_en  in  1  inst master request and write enable.
- i_m0_addr  in  ADDR_WIDTH  inst master address.
- i_m0_w_data  in  DATA_WIDTH  inst master write data.
- i_m0_w_size  in  mem_w_size_e  inst master write size.
- o_m0_ready  out  1  inst handshake; transfer completes at the next edge.
- o_m0_r_data  out  DATA_WIDTH  inst read data, one cycle after the handshake.
- i_m1_* / o_m1_*  same as m0  data master.
- o_s_valid, o_s_w_en, o_s_addr, o_s_w_data, o_s_w_size  out  as above  slave request.
- i_s_ready  in  1  slave ready.
- i_s_r_data  in  DATA_WIDTH  slave read data.

Behaviour:
- Transfer definition: a transfer occurs on an i_clk rising edge where o_s_valid && i_s_ready.
- Masters hold valid and request fields stable until they see ready.
- State machine (r_state):
  - IDLE: no grant is locked.
  - LOCK_M0 / LOCK_M1: a grant is locked.
- IDLE grant selection (combinational):
  - Only one master valid: grant it.
  - Both valid: grant the master that did not win the last transfer (r_last). If no transfer since reset, use DATA_PRIORITY.
- Forwarding: the granted master's request fields drive the o_s_* outputs.
- Ready: o_mX_ready = i_s_ready for the granted master only; the ungranted master sees ready = 0.
- IDLE transitions:
  - Granted and i_s_ready = 0: enter LOCK_<granted>. The grant is frozen until the transfer, even if the other master asserts valid.
  - Granted and i_s_ready = 1: transfer completes; stay in IDLE and update r_last.
- LOCK_X: forward master X only. On transfer -> IDLE, r_last <= X.
- LOCK_X with master X dropping valid (protocol violation): return to IDLE next cycle with no transfer and no r_last update.
- Response routing:
  - On every transfer, r_rsp_owner <= granted master.
  - Next cycle, i_s_r_data is routed to o_mX_r_data of r_rsp_owner. The other master's r_data is driven 0.
  - Back-to-back transfers to different masters route correctly every cycle.
- No requests: o_s_valid = 0, all other o_s_* = 0, both ready = 0.
- Reset values:
  - r_state = IDLE, r_last = "none", r_rsp_owner = M0.
  - All outputs 0.
- Reset asserted mid-lock clears the state immediately; no transfer is issued.
- Latency: zero added cycles when uncontended. Under contention, the losing master waits one transfer.
- Fairness: with both masters continuously valid and the slave always ready, grants alternate M1, M0, M1, … (DATA_PRIORITY = 1).

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, add three 32-bit outputs:
  - o_m0_xfer_cnt, o_m1_xfer_cnt: completed transfers per master.
  - o_conflict_cnt: cycles where both masters are valid in IDLE, or the locked master's peer is valid.
- Counters wrap at 2^32. Reset to 0 by i_rst_n.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Uncontended inst read: m0 valid, addr 0x00000010, s_ready = 1, slave returns 0xDEADBEEF next cycle -> m0_ready = 1 same cycle; m0_r_data = 0xDEADBEEF next cycle; m1 sees ready = 0.
- Simultaneous requests after reset: m0 addr 0x100, m1 addr 0x10000004, s_ready = 1 -> m1 granted first, then m0; s_addr sequence 0x10000004, 0x100; r_data routed to m1, then m0.
- Lock: m0 valid, s_ready = 0 for 3 cycles, m1 valid from cycle 1 -> s_addr stays m0's for 4 cycles; m0 transfers on cycle 3; m1 granted cycle 4.
- Sustained contention, s_ready = 1 for 8 cycles -> grants alternate M1, M0 ×4; each r_data goes to the correct master.
- Reset mid-lock: assert i_rst_n = 0 during LOCK_M1 -> o_s_valid = 0 immediately; after release, with both valid, M1 is granted (history cleared).
- With MEM_ARB_PERF_CNT_EN: 5 m0 and 3 m1 transfers with 2 conflict cycles -> counters read 5, 3, 2.
